// File: rtl/bn_fp16_pkg.sv
// -----------------------------------------------------------------------------
// bn_fp16_pkg
// Shared FP16 definitions for the BN datapath (divide, multiply, quantize).
// Contents:
//   FP16_* field constants       - widths, bias and the all-ones exponent code
//   fp16_t                       - packed {sign, exp, man} view of a 16-bit word
//   fp16_cls_e / fp16_classify() - coarse class of an FP16 value
// Subnormals are classed as zero because the BN stages flush them to zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package bn_fp16_pkg;

  localparam int FP16_EXP_W       = 5;
  localparam int FP16_MAN_W       = 10;
  localparam int FP16_EXP_BIAS    = 15;
  localparam int FP16_EXP_SPECIAL = 31;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

  typedef enum logic [1:0] {
    FP16_CLS_ZERO = 2'd0,  // zero or subnormal (flushed)
    FP16_CLS_NORM = 2'd1,
    FP16_CLS_INF  = 2'd2,
    FP16_CLS_NAN  = 2'd3
  } fp16_cls_e;

  function automatic fp16_cls_e fp16_classify(input fp16_t x);
    fp16_cls_e cls;
    if (x.exp == '0) begin
      cls = FP16_CLS_ZERO;
    end else if (x.exp == FP16_EXP_W'(FP16_EXP_SPECIAL)) begin
      cls = (x.man == '0) ? FP16_CLS_INF : FP16_CLS_NAN;
    end else begin
      cls = FP16_CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp16_mag_shift.sv
// -----------------------------------------------------------------------------
// fp16_mag_shift
// Combinational first half of the FP16 -> fixed-point quantizer: classifies
// the input and aligns the 11-bit significand onto the output grid with one
// extra guard bit below the output LSB, so the next stage can round.
// Ports:
//   i_data   [15:0]      FP16 word
//   o_sign               sign bit of the input
//   o_mag_g  [OUT_W+1:0] magnitude in units of 2^-(FRAC_W+1) (truncated)
//   o_sat                value is out of range (exponent overflow or inf)
// Zero, subnormal and NaN inputs yield magnitude 0 with o_sat low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fp16_mag_shift
  import bn_fp16_pkg::*;
#(
  parameter int OUT_W  = 8,
  parameter int FRAC_W = 4
) (
  input  logic [15:0]      i_data,
  output logic             o_sign,
  output logic [OUT_W+1:0] o_mag_g,
  output logic             o_sat
);

  fp16_t               w_fp;
  fp16_cls_e           w_cls;
  logic [FP16_MAN_W:0] w_man_full;
  // Weight of the implicit leading one, as a power of two in output LSBs.
  int                  w_lead_pos;
  // Shift applied to the 11-bit significand to land on the guard-bit grid.
  int                  w_k;

  assign w_fp = i_data;

  always_comb begin
    w_cls      = fp16_classify(w_fp);
    w_man_full = {1'b1, w_fp.man};
    w_lead_pos = int'(w_fp.exp) - FP16_EXP_BIAS + FRAC_W;
    w_k        = w_lead_pos - FP16_MAN_W + 1;

    o_sign  = w_fp.sign;
    o_sat   = 1'b0;
    o_mag_g = '0;

    case (w_cls)
      FP16_CLS_INF: begin
        o_sat   = 1'b1;
        o_mag_g = '1;
      end
      FP16_CLS_NORM: begin
        if (w_lead_pos >= OUT_W) begin
          // Leading one alone already exceeds the output range.
          o_sat   = 1'b1;
          o_mag_g = '1;
        end else if (w_k >= 0) begin
          // In range, so the shifted value always fits the guard-bit width;
          // truncating the significand before the shift loses nothing.
          o_mag_g = (OUT_W+2)'(w_man_full) << w_k;
        end else if (w_k >= -(FP16_MAN_W + 1)) begin
          o_mag_g = (OUT_W+2)'(w_man_full >> (-w_k));
        end else begin
          o_mag_g = '0;
        end
      end
      default: begin
        o_mag_g = '0;
      end
    endcase
  end

endmodule

// File: rtl/fp16_to_fixed_quant.sv
// -----------------------------------------------------------------------------
// fp16_to_fixed_quant
// Two-stage streaming converter from FP16 (BN output) to signed OUT_W-bit
// fixed point with FRAC_W fractional bits. Rounds half away from zero and
// saturates; a sideband tag travels with each sample; saturated output beats
// are counted in a sticky 16-bit debug counter.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready       input handshake, s_ready = !m_valid || m_ready
//   s_data [15:0]         FP16 sample
//   s_tag  [TAG_W-1:0]    sideband tag (channel index)
//   m_valid/m_ready       output handshake
//   m_data [OUT_W-1:0]    quantized result
//   m_tag  [TAG_W-1:0]    tag aligned with m_data
//   m_sat                 m_data was clipped (or input was inf)
//   sat_cnt [15:0]        accepted saturated beats, sticks at 0xFFFF
//   clr_cnt               synchronous clear of sat_cnt, wins over increment
// Build option:
//   QUANT_RELU_EN         when defined, negative results (incl. -inf) give 0
//                         with m_sat low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fp16_to_fixed_quant
  import bn_fp16_pkg::*;
#(
  parameter int OUT_W  = 8,
  parameter int FRAC_W = 4,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic             m_sat,
  output logic [15:0]      sat_cnt,
  input  logic             clr_cnt
);

  // Output limits and the same limits widened to the rounded magnitude width.
  localparam logic [OUT_W-1:0] L_POS_LIM  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] L_NEG_LIM  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   L_POS_MAXW = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   L_NEG_MAXW = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] L_ONE      = {{(OUT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Handshake: one shared advance enable for both stages.
  // ---------------------------------------------------------------------------
  logic w_adv;

  // Stage 1 registers
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [OUT_W+1:0] r_s1_mag_g;
  logic             r_s1_sat;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 2 (output) registers
  logic             r_s2_valid;
  logic [OUT_W-1:0] r_s2_data;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_sat;

  logic [15:0]      r_sat_cnt;

  assign w_adv   = !r_s2_valid || m_ready;
  assign s_ready = w_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: decode / classify / align
  // ---------------------------------------------------------------------------
  logic             w_dec_sign;
  logic [OUT_W+1:0] w_dec_mag_g;
  logic             w_dec_sat;

  fp16_mag_shift #(
    .OUT_W  (OUT_W),
    .FRAC_W (FRAC_W)
  ) u_mag_shift (
    .i_data  (s_data),
    .o_sign  (w_dec_sign),
    .o_mag_g (w_dec_mag_g),
    .o_sat   (w_dec_sat)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: round / apply sign / saturate
  // ---------------------------------------------------------------------------
  logic [OUT_W:0]   w_mag;
  logic [OUT_W-1:0] w_q_data;
  logic             w_q_sat;

  always_comb begin
    // (g + 1) >> 1 written as (g >> 1) + g[0]: the guard bit rounds the
    // magnitude up, which is half-away-from-zero once the sign is applied.
    w_mag    = r_s1_mag_g[OUT_W+1:1] + {{OUT_W{1'b0}}, r_s1_mag_g[0]};
    w_q_data = '0;
    w_q_sat  = 1'b0;

    if (r_s1_sat) begin
      w_q_sat  = 1'b1;
      w_q_data = r_s1_sign ? L_NEG_LIM : L_POS_LIM;
    end else if (!r_s1_sign) begin
      if (w_mag > L_POS_MAXW) begin
        w_q_sat  = 1'b1;
        w_q_data = L_POS_LIM;
      end else begin
        w_q_data = w_mag[OUT_W-1:0];
      end
    end else begin
      if (w_mag > L_NEG_MAXW) begin
        w_q_sat  = 1'b1;
        w_q_data = L_NEG_LIM;
      end else begin
        // Negating a zero magnitude gives zero, so -0 never appears.
        w_q_data = ~w_mag[OUT_W-1:0] + L_ONE;
      end
    end

`ifdef QUANT_RELU_EN
    if (r_s1_sign) begin
      w_q_data = '0;
      w_q_sat  = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Data registers only load on a valid beat so that the
  // last output value stays put across bubbles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag_g <= '0;
      r_s1_sat   <= 1'b0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
      r_s2_sat   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= s_valid;
      if (s_valid) begin
        r_s1_sign  <= w_dec_sign;
        r_s1_mag_g <= w_dec_mag_g;
        r_s1_sat   <= w_dec_sat;
        r_s1_tag   <= s_tag;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_q_data;
        r_s2_tag  <= r_s1_tag;
        r_s2_sat  <= w_q_sat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturation event counter (counts beats actually taken downstream).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (clr_cnt) begin
      r_sat_cnt <= '0;
    end else if (r_s2_valid && m_ready && r_s2_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign m_valid = r_s2_valid;
  assign m_data  = r_s2_data;
  assign m_tag   = r_s2_tag;
  assign m_sat   = r_s2_sat;
  assign sat_cnt = r_sat_cnt;

endmodule
